// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants for the sprite ROM arbiter: sprite geometry, ROM word format
// and the round-robin pointer helper.
package sprite_rom_arbiter_pkg;

  localparam int SPRITE_W     = 22;
  localparam int SPRITE_H     = 22;
  localparam int SPRITE_WORDS = SPRITE_W * SPRITE_H;
  localparam int SPRITE_AW    = $clog2(SPRITE_WORDS);
  localparam int RGB_DW       = 12;
  localparam int DEF_ROM_LAT  = 1;

  // Wide enough for N_REQ up to 8.
  typedef logic [2:0] ptr_t;

  // Pointer value following requester k; wraps from n_req-1 back to 1.
  function automatic ptr_t next_ptr(input ptr_t k, input int n_req);
    if (k >= ptr_t'(n_req - 1)) begin
      next_ptr = 3'd1;
    end else begin
      next_ptr = k + 3'd1;
    end
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker over requesters 1..N_REQ-1.
// Bit p-1 of req_hi/pick corresponds to requester p; the scan starts at rr_ptr.
module sprite_rom_arbiter_rr_pick
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-2:0] req_hi,
  input  ptr_t             rr_ptr,
  output logic [N_REQ-2:0] pick
);

  logic found_s;
  int   idx_s;

  // Scan from rr_ptr with wrap; the first active requester wins.
  always_comb begin
    pick    = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int s = 0; s < N_REQ - 1; s++) begin
      idx_s = int'(rr_ptr) + s;
      if (idx_s > N_REQ - 1) begin
        idx_s = idx_s - (N_REQ - 1);
      end else begin
        idx_s = idx_s;
      end
      for (int p = 1; p < N_REQ; p++) begin
        if (!found_s && (p == idx_s) && req_hi[p-1]) begin
          pick[p-1] = 1'b1;
          found_s   = 1'b1;
        end else begin
          found_s   = found_s;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM: requester 0 has absolute priority, the
// rest are served round-robin; read tags follow the ROM latency back to owners.
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int AW      = SPRITE_AW,
  parameter int DW      = RGB_DW,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] addr,
  output logic [N_REQ-1:0]    gnt,
  output logic                rom_en,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data,
  output logic [DW-1:0]       rdata,
  output logic [N_REQ-1:0]    rvalid
);

  ptr_t             rr_ptr_r;
  ptr_t             gnt_idx_s;
  logic [N_REQ-2:0] pick_s;
  logic [N_REQ-1:0] tag_r [ROM_LAT];

  sprite_rom_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req_hi (req[N_REQ-1:1]),
    .rr_ptr (rr_ptr_r),
    .pick   (pick_s)
  );

  // Fixed-priority override on top of the round-robin pick; silent in reset.
  always_comb begin
    gnt = '0;
    if (clrn) begin
      gnt = '0;
    end else if (req[0]) begin
      gnt = {{(N_REQ-1){1'b0}}, 1'b1};
    end else begin
      gnt = {pick_s, 1'b0};
    end
  end

  // Address mux and index of the winner; gnt is one-hot so OR-merging is safe.
  always_comb begin
    rom_addr  = '0;
    gnt_idx_s = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      rom_addr  = rom_addr | (addr[i*AW +: AW] & {AW{gnt[i]}});
      gnt_idx_s = gnt_idx_s | (ptr_t'(i) & {3{gnt[i]}});
    end
  end

  assign rom_en = |gnt;
  assign rdata  = rom_data;
  assign rvalid = tag_r[ROM_LAT-1];

  // Round-robin pointer moves past a granted peer; requester 0 and idle leave it alone.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      rr_ptr_r <= 3'd1;
    end else if (rom_en && !gnt[0]) begin
      rr_ptr_r <= next_ptr(gnt_idx_s, N_REQ);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Owner tags travel alongside the ROM read; reset drops reads in flight.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      for (int j = 0; j < ROM_LAT; j++) begin
        tag_r[j] <= '0;
      end
    end else begin
      tag_r[0] <= gnt;
      for (int j = 1; j < ROM_LAT; j++) begin
        tag_r[j] <= tag_r[j-1];
      end
    end
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-port sprite ROM (22x22 sprite, 484 words of 12-bit RGB) among several requesters.
- Typical requesters: the pixel renderer, the collision checker and the title/overlay drawer.
- Requester 0 is the display path and always has absolute priority. The remaining requesters are served round-robin.
- Each read result returns to its owner with a one-hot valid, after the ROM's fixed read latency.

Parameters:
- N_REQ, default 3: number of requesters; legal range 2..8.
- AW, default 9: ROM address width (484 words fit in 9 bits).
- DW, default 12: ROM data width, {r,g,b} 4 bits each.
- ROM_LAT, default 1: cycles from the ROM address edge to valid rom_data; legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- clrn  in  1  reset, asynchronous and active-high: asserting it high resets the block immediately, independent of clk.
- req  in  N_REQ  per-requester read request; held until granted.
- addr  in  N_REQ*AW  flattened addresses; requester i occupies bits [i*AW +: AW].
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as the winning req.
- rom_en  out  1  ROM read enable; equals |gnt.
- rom_addr  out  AW  address of the granted requester; 0 when no grant.
- rom_data  in  DW  ROM read data, valid ROM_LAT cycles after rom_en.
- rdata  out  DW  returned data; equals rom_data.
- rvalid  out  N_REQ  one-hot: rdata belongs to requester i this cycle.

Behaviour:
- Arbitration (combinational from req, rr_ptr and reset):
  - If req[0] is high, gnt = 1 (bit 0 only).
  - Otherwise, scan requesters 1..N_REQ-1 starting at rr_ptr, wrapping from N_REQ-1 back to 1; the first active req wins.
  - If no req is active, gnt = 0.
- rr_ptr update (registered):
  - Range 1..N_REQ-1; reset value 1.
  - When requester k>=1 is granted, rr_ptr <= k+1, wrapping from N_REQ-1 back to 1.
  - No change when requester 0 wins or when idle.
- Starvation: continuous req[0] starves all others. This is intended (display deadline); no starvation guard.
- Handshake:
  - A requester drops req or changes addr only in a cycle after gnt was seen.
  - One grant serves one word; back-to-back grants to the same requester are allowed.
  - Throughput: one read per cycle.
- Return path:
  - Tag pipeline of ROM_LAT stages, each N_REQ bits wide.
  - Stage 0 <= gnt; stage j <= stage j-1.
  - rvalid = final stage, so rvalid[i] rises exactly ROM_LAT cycles after gnt[i].
  - rdata = rom_data unregistered; the arbiter adds no latency of its own.
- Reset, while clrn is high:
  - gnt, rom_en, rom_addr and rvalid are forced to 0.
  - rr_ptr is held at 1; all tag stages are held at 0.
- Reset mid-operation: in-flight reads are discarded and never produce rvalid. The requester re-issues after reset.
- Simultaneous events: req[0] rising in the same cycle that rr_ptr points to a waiting requester: requester 0 wins and rr_ptr is unchanged.
- Out-of-range addresses (>=484): passed through unchanged; the ROM contents there are don't-care.
- Invariants:
  - gnt and rvalid are always one-hot or zero.
  - rom_en == |gnt.
  - The popcount of all tag stages never exceeds ROM_LAT.

Decomposition:
- Shared package: sprite width and height constants (22, 22), sprite word count 484, SPRITE_AW = 9, RGB_DW = 12, default ROM_LAT.
- One sub-module, rr_pick: combinational round-robin picker over requesters 1..N_REQ-1, taking req and rr_ptr and producing a one-hot grant.
- The fixed-priority override, rr_ptr register and tag pipeline stay in the top module.

Test Plan:
- Reset, then idle (req = 0) -> gnt = 0, rom_en = 0, rom_addr = 0, rvalid = 0 for 10 cycles.
- Single read, ROM_LAT = 1: req = 3'b010 with addr1 = 9'd23 -> gnt = 010 and rom_addr = 23 in the same cycle; rvalid = 010 one cycle later, with rdata equal to ROM word 23.
- Priority: req = 3'b111 held 4 cycles -> gnt = 001 every cycle and rr_ptr stays 1. Then req = 3'b110 -> gnt sequence 010, 100, 010, 100.
- Pipelining, ROM_LAT = 3: grants to 0, 1, 2 on consecutive cycles -> rvalid = 001, 010, 100 on cycles +3, +4, +5, with matching rdata.
- Reset mid-flight, ROM_LAT = 2: grant requester 2, pulse clrn high for 1 cycle between clock edges -> rvalid stays 0 throughout, and rr_ptr = 1 after release.
- Random stress, 10k cycles, with requesters obeying the hold rule -> every grant is matched by exactly one rvalid ROM_LAT later, and no requester 1..N_REQ-1 waits more than N_REQ-2 of its peers' grants while req[0] is low.
